// File: rtl/btn_pkg.sv
// Shared push-button timing constants and the event-decoder state encoding.
// Debouncer and decoder both pull their cycle counts from here.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_HELD  = 2'd2
    } btn_state_t;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEBOUNCE_SETTLE_CNT = 1_000_000;   // 20 ms
    localparam int LONG_CNT_DEFAULT    = 25_000_000;  // 0.5 s
    localparam int REPEAT_CNT_DEFAULT  = 5_000_000;   // 0.1 s
    localparam int CNT_W_DEFAULT       = 25;

    // True when a counter of width w can hold the terminal value cnt-1.
    function automatic bit cnt_fits(input int cnt, input int w);
        return (w >= 31) || ((cnt - 1) < (1 << w));
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// One-cycle delay of the debounced button level with falling/rising edge strobes.
// The delay register resets high so a button held through reset still yields a fall.
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall,
    output logic rise
);

    logic din_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_d <= 1'b1;
        end else begin
            din_d <= din;
        end
    end

    assign fall = din_d & ~din;
    assign rise = ~din_d & din;

endmodule

// File: rtl/btn_event_decoder.sv
// Turns the debounced active-low button level into registered single-cycle events:
// press, release, short click, long press and auto-repeat while held.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int LONG_CNT   = LONG_CNT_DEFAULT,
    parameter int REPEAT_CNT = REPEAT_CNT_DEFAULT,
    parameter bit REPEAT_EN  = 1'b1,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bot_in,
    output logic       press,
    output logic       release_pulse,  // "release" is a reserved word
    output logic       short_click,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output btn_state_t dbg_state
);

    if (LONG_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_cnt
        $error("btn_event_decoder: LONG_CNT and REPEAT_CNT must be >= 2");
    end
    if (!cnt_fits(LONG_CNT, CNT_W) || !cnt_fits(REPEAT_CNT, CNT_W)) begin : g_bad_width
        $error("btn_event_decoder: CNT_W too narrow for LONG_CNT/REPEAT_CNT");
    end

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CNT - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall, rise;
    logic             press_d, release_d, short_d, long_d, repeat_d;

    btn_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (bot_in),
        .fall (fall),
        .rise (rise)
    );

    // Once out of IDLE the delayed level is always low, so rise == (bot_in == 1).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_SHORT;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ST_SHORT: begin
                if (rise) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                end else if (cnt_q == LONG_TERM) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (rise) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_TERM) begin
                    cnt_d    = '0;
                    repeat_d = REPEAT_EN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press         <= press_d;
            release_pulse <= release_d;
            short_click   <= short_d;
            long_press    <= long_d;
            repeat_pulse  <= repeat_d;
        end
    end

    assign held      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: two instances (repeat on/off) fed the same button,
// compared every cycle against a sample-index model plus directed latency checks.
module tb_btn_event_decoder;
    import btn_pkg::*;

    localparam int LONG = 8;
    localparam int REP  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bot_in = 1'b0;
    always #5 clk = ~clk;

    logic press_r, release_r, short_r, long_r, rep_r, held_r;
    logic press_n, release_n, short_n, long_n, rep_n, held_n;
    btn_state_t dbg_r, dbg_n;

    btn_event_decoder #(.LONG_CNT(LONG), .REPEAT_CNT(REP), .REPEAT_EN(1'b1), .CNT_W(4)) dut_rep (
        .clk(clk), .rst(rst), .bot_in(bot_in),
        .press(press_r), .release_pulse(release_r), .short_click(short_r),
        .long_press(long_r), .repeat_pulse(rep_r), .held(held_r), .dbg_state(dbg_r)
    );

    btn_event_decoder #(.LONG_CNT(LONG), .REPEAT_CNT(REP), .REPEAT_EN(1'b0), .CNT_W(4)) dut_norep (
        .clk(clk), .rst(rst), .bot_in(bot_in),
        .press(press_n), .release_pulse(release_n), .short_click(short_n),
        .long_press(long_n), .repeat_pulse(rep_n), .held(held_n), .dbg_state(dbg_n)
    );

    // {press, release, short_click, long_press, repeat_pulse, held}
    logic [5:0] obs_r, obs_n;
    assign obs_r = {press_r, release_r, short_r, long_r, rep_r, held_r};
    assign obs_n = {press_n, release_n, short_n, long_n, rep_n, held_n};

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [5:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the index k of the current sample since the first low sample.
    bit m_active = 1'b0;
    bit m_prev   = 1'b1;
    int m_k      = 0;

    task automatic model_reset();
        m_active = 1'b0;
        m_prev   = 1'b1;
        m_k      = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic b);
        logic [5:0] e;
        e = '0;
        if (!m_active) begin
            if (m_prev && !b) begin
                m_active = 1'b1;
                m_k      = 0;
                e[5]     = 1'b1;
            end
        end else begin
            m_k++;
            if (b) begin
                m_active = 1'b0;
                e[4]     = 1'b1;
                e[3]     = (m_k <= LONG);
            end else if (m_k == LONG) begin
                e[2] = 1'b1;
            end else if (m_k > LONG && ((m_k - LONG) % REP) == 0) begin
                e[1] = 1'b1;
            end
        end
        e[0]   = m_active;
        m_prev = b;
        exp_q.push_back(e);
    endtask

    // ---------------- event trackers for directed latency checks ----------------
    int cyc, first_press, first_release, first_long, first_long_n, first_rep, last_rep;
    int n_rep, n_rep_n, n_short, n_held, n_held_n;

    task automatic scen_start();
        cyc = 0;
        first_press = -1; first_release = -1; first_long = -1; first_long_n = -1;
        first_rep = -1; last_rep = -1;
        n_rep = 0; n_rep_n = 0; n_short = 0; n_held = 0; n_held_n = 0;
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; drives one sample, checks the outputs registered from it.
    task automatic step(input logic b);
        logic [5:0] e;
        bot_in = b;
        @(posedge clk);
        model_step(b);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq("outputs_rep_en1", 32'(obs_r), 32'(e));
        check_eq("outputs_rep_en0", 32'(obs_n), 32'({e[5:2], 1'b0, e[0]}));
        if (press_r && first_press < 0)     first_press = cyc + 1;
        if (release_r && first_release < 0) first_release = cyc + 1;
        if (long_r && first_long < 0)       first_long = cyc + 1;
        if (long_n && first_long_n < 0)     first_long_n = cyc + 1;
        if (rep_r) begin
            if (first_rep < 0) first_rep = cyc + 1;
            last_rep = cyc + 1;
            n_rep++;
        end
        if (rep_n)   n_rep_n++;
        if (short_r) n_short++;
        if (held_r)  n_held++;
        if (held_n)  n_held_n++;
        cyc++;
    endtask

    task automatic steps(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_rep_en1"}, 32'(obs_r), 32'd0);
        check_eq({tag, "_rep_en0"}, 32'(obs_n), 32'd0);
        check_eq({tag, "_state"}, 32'(dbg_r), 32'(ST_IDLE));
    endtask

    // Asserts rst between a negedge and the next posedge, holds it, releases at a negedge.
    task automatic async_reset(input int hold_cycles);
        #2 rst = 1'b1;
        #1 check_quiet("rst_async");
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            check_quiet("rst_hold");
        end
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held from time 0 with the button low.
        bot_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("rst_init");
        end
        rst = 1'b0;
        model_reset();
        scen_start();
        step(1'b0);
        check_eq("rst_press_latency", 32'(first_press), 32'd1);
        steps(1'b0, 2);
        steps(1'b1, 3);

        // Short click: low 0-4, high at 5.
        scen_start();
        steps(1'b0, 5);
        steps(1'b1, 4);
        check_eq("short_press_at", 32'(first_press), 32'd1);
        check_eq("short_release_at", 32'(first_release), 32'd6);
        check_eq("short_click_count", 32'(n_short), 32'd1);
        check_eq("short_no_long", 32'(first_long), 32'hffffffff);
        check_eq("short_held_cycles", 32'(n_held), 32'd5);

        // Long hold: low 0-20, high at 21.
        scen_start();
        steps(1'b0, 21);
        steps(1'b1, 3);
        check_eq("long_press_at", 32'(first_press), 32'd1);
        check_eq("long_long_at", 32'(first_long), 32'd9);
        check_eq("long_first_rep", 32'(first_rep), 32'd13);
        check_eq("long_last_rep", 32'(last_rep), 32'd21);
        check_eq("long_rep_count", 32'(n_rep), 32'd3);
        check_eq("long_release_at", 32'(first_release), 32'd22);
        check_eq("long_no_short", 32'(n_short), 32'd0);

        // Release on the same sample as the long terminal count.
        scen_start();
        steps(1'b0, 8);
        steps(1'b1, 3);
        check_eq("simul_release_at", 32'(first_release), 32'd9);
        check_eq("simul_short", 32'(n_short), 32'd1);
        check_eq("simul_no_long", 32'(first_long), 32'hffffffff);

        // Hold 30 cycles: the REPEAT_EN=0 instance never repeats.
        scen_start();
        steps(1'b0, 30);
        steps(1'b1, 3);
        check_eq("norep_long_at", 32'(first_long_n), 32'd9);
        check_eq("norep_rep_count", 32'(n_rep_n), 32'd0);
        check_eq("norep_held_cycles", 32'(n_held_n), 32'd30);

        // Async reset mid-HELD with the button still low.
        scen_start();
        steps(1'b0, 15);
        check_eq("midheld_held", 32'(held_r), 32'd1);
        async_reset(2);
        scen_start();
        steps(1'b0, 10);
        check_eq("postrst_press_at", 32'(first_press), 32'd1);
        check_eq("postrst_long_at", 32'(first_long), 32'd9);
        check_eq("postrst_no_release", 32'(first_release), 32'hffffffff);
        steps(1'b1, 2);

        // Random presses of assorted lengths with occasional resets.
        for (int i = 0; i < 60; i++) begin
            steps(1'b0, int'($urandom_range(1, 26)));
            if ($urandom_range(0, 7) == 0) begin
                async_reset(int'($urandom_range(0, 2)));
                steps(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
            end
            steps(1'b1, int'($urandom_range(1, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
